sram_1rw1r: RTL and testbench

Parametrised synchronous SRAM behavioural model with one read/write port (port 0) and one read-only port (port 1). It is the next-generation on-chip memory model for instruction/data memories and register-file-style buffers.
New over the single-port model:
- configurable write granule;
- defined read-during-write collision policy;
- per-port read-valid flags;
- optional hardware clear sweep after reset, with a busy flag.

---
 rtl/sram_1rw1r_if.sv | 29 ++
 rtl/sram_1rw1r.sv | 104 ++++++++++
 tb/tb_sram_1rw1r.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/sram_1rw1r_if.sv
// Request/response bundle for the 1RW+1R SRAM.
// Port 0 reads and writes, port 1 only reads, and busy flags the clear sweep.
interface sram_1rw1r_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_WMASKS = 4
);
    logic                  csb0;
    logic                  web0;
    logic [NUM_WMASKS-1:0] wmask0;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [DATA_WIDTH-1:0] din0;
    logic [DATA_WIDTH-1:0] dout0;
    logic                  dout0_valid;
    logic                  csb1;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [DATA_WIDTH-1:0] dout1;
    logic                  dout1_valid;
    logic                  busy;

    modport master (
        output csb0, web0, wmask0, addr0, din0, csb1, addr1,
        input  dout0, dout0_valid, dout1, dout1_valid, busy
    );
    modport slave (
        input  csb0, web0, wmask0, addr0, din0, csb1, addr1,
        output dout0, dout0_valid, dout1, dout1_valid, busy
    );
endinterface

// File: rtl/sram_1rw1r.sv
// Synchronous 1RW + 1R SRAM model with granule write masks, a selectable
// read-during-write policy on port 1 and an optional zeroing sweep after reset.
module sram_1rw1r #(
    parameter int    DATA_WIDTH     = 32,
    parameter int    WMASK_WIDTH    = 8,
    parameter int    NUM_WMASKS     = DATA_WIDTH / WMASK_WIDTH,
    parameter int    ADDR_WIDTH     = 8,
    parameter int    RAM_DEPTH      = 1 << ADDR_WIDTH,
    parameter string IFILE          = "",
    parameter int    CLEAR_ON_RESET = 0,
    parameter int    RDW_MODE       = 0
) (
    input  logic          clk0,
    input  logic          rst0,
    sram_1rw1r_if.slave   bus
);
    if (DATA_WIDTH % WMASK_WIDTH != 0) begin : g_bad_mask
        $error("DATA_WIDTH must be a multiple of WMASK_WIDTH");
    end
    if (RAM_DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_depth
        $error("RAM_DEPTH exceeds the address space");
    end

    localparam logic [ADDR_WIDTH:0]   DEPTH_L = (ADDR_WIDTH+1)'(RAM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(RAM_DEPTH - 1);

    typedef enum logic {IDLE, CLEAR} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [DATA_WIDTH-1:0] dout0_q, dout1_q;
    logic                  dout0_valid_q, dout1_valid_q;

    logic [DATA_WIDTH-1:0] mem [0:RAM_DEPTH-1];

    initial begin
        for (int i = 0; i < RAM_DEPTH; i++) mem[i] = '0;
    end

    logic                  busy, in0, in1, re0, we0, re1, hit;
    logic [DATA_WIDTH-1:0] rd0, rd1, wr_word;

    assign busy = (state_q == CLEAR);
    assign in0  = {1'b0, bus.addr0} < DEPTH_L;
    assign in1  = {1'b0, bus.addr1} < DEPTH_L;
    assign re0  = !busy && !bus.csb0 &&  bus.web0;
    assign we0  = !busy && !bus.csb0 && !bus.web0;
    assign re1  = !busy && !bus.csb1;
    assign rd0  = in0 ? mem[bus.addr0] : '0;
    assign rd1  = in1 ? mem[bus.addr1] : '0;
    assign hit  = we0 && in0 && (bus.addr0 == bus.addr1);

    for (genvar k = 0; k < NUM_WMASKS; k++) begin : g_gran
        assign wr_word[k*WMASK_WIDTH +: WMASK_WIDTH] = bus.wmask0[k]
            ? bus.din0[k*WMASK_WIDTH +: WMASK_WIDTH]
            : rd0[k*WMASK_WIDTH +: WMASK_WIDTH];
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            CLEAR: begin
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == LAST) begin
                    state_d = IDLE;
                    ptr_d   = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            state_q       <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
            ptr_q         <= '0;
            dout0_q       <= '0;
            dout1_q       <= '0;
            dout0_valid_q <= 1'b0;
            dout1_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            dout0_valid_q <= re0;
            dout1_valid_q <= re1;
            if (re0) dout0_q <= rd0;
            // Same-address collision: old word by default, merged word in mode 1.
            if (re1) dout1_q <= (RDW_MODE == 1 && hit) ? wr_word : rd1;
        end
    end

    // The array is not reset, so it lives outside the reset process.
    always @(posedge clk0) begin
        if (busy)            mem[ptr_q]     <= '0;
        else if (we0 && in0) mem[bus.addr0] <= wr_word;
    end

    assign bus.dout0       = dout0_q;
    assign bus.dout1       = dout1_q;
    assign bus.dout0_valid = dout0_valid_q;
    assign bus.dout1_valid = dout1_valid_q;
    assign bus.busy        = busy;
endmodule

// File: tb/tb_sram_1rw1r.sv
// Random + directed bench for two sram_1rw1r configurations against a word-array model.
module tb_sram_1rw1r;
    logic clk = 1'b0;
    logic rst_a, rst_b;
    always #5 clk = ~clk;

    sram_1rw1r_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .NUM_WMASKS(4)) ifa();
    sram_1rw1r_if #(.DATA_WIDTH(64), .ADDR_WIDTH(8), .NUM_WMASKS(4)) ifb();

    sram_1rw1r u_a (.clk0(clk), .rst0(rst_a), .bus(ifa.slave));
    sram_1rw1r #(.DATA_WIDTH(64), .WMASK_WIDTH(16), .ADDR_WIDTH(8), .RAM_DEPTH(200),
                 .CLEAR_ON_RESET(1), .RDW_MODE(1))
        u_b (.clk0(clk), .rst0(rst_b), .bus(ifb.slave));

    logic [31:0] ma [256];
    logic [63:0] mb [256];
    logic [31:0] ea0, ea1;
    logic [63:0] eb0, eb1;
    logic        eav0, eav1, ebv0, ebv1;
    int          bcnt;
    int          n_tests = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] expand(input logic [3:0] m, input int g);
        logic [63:0] r = '0;
        for (int k = 0; k < 4; k++)
            for (int b = 0; b < g; b++) r[k*g+b] = m[k];
        return r;
    endfunction

    task automatic idle();
        ifa.csb0 = 1; ifa.web0 = 1; ifa.wmask0 = 0; ifa.addr0 = 0; ifa.din0 = 0;
        ifa.csb1 = 1; ifa.addr1 = 0;
        ifb.csb0 = 1; ifb.web0 = 1; ifb.wmask0 = 0; ifb.addr0 = 0; ifb.din0 = 0;
        ifb.csb1 = 1; ifb.addr1 = 0;
    endtask

    task automatic rnd();
        ifa.csb0 = ($urandom_range(0, 3) == 0); ifa.web0 = $urandom_range(0, 1);
        ifa.wmask0 = 4'($urandom); ifa.addr0 = 8'($urandom_range(0, 15));
        ifa.din0 = $urandom; ifa.csb1 = ($urandom_range(0, 3) == 0);
        ifa.addr1 = 8'($urandom_range(0, 15));
        ifb.csb0 = ($urandom_range(0, 3) == 0); ifb.web0 = $urandom_range(0, 1);
        ifb.wmask0 = 4'($urandom);
        ifb.addr0 = 8'($urandom_range(0, 1) ? $urandom_range(0, 15) : $urandom_range(190, 255));
        ifb.din0 = {$urandom, $urandom}; ifb.csb1 = ($urandom_range(0, 3) == 0);
        ifb.addr1 = 8'($urandom_range(0, 1) ? $urandom_range(0, 15) : $urandom_range(190, 255));
    endtask

    // One clock edge: apply the memory rules to the model, then compare everything.
    task automatic step();
        logic [63:0] m;
        @(posedge clk);
        if (!ifa.csb1) begin ea1 = ma[ifa.addr1]; eav1 = 1; end else eav1 = 0;
        if (!ifa.csb0 && ifa.web0) begin ea0 = ma[ifa.addr0]; eav0 = 1; end else eav0 = 0;
        if (!ifa.csb0 && !ifa.web0) begin
            m = expand(ifa.wmask0, 8);
            ma[ifa.addr0] = (ma[ifa.addr0] & ~m[31:0]) | (ifa.din0 & m[31:0]);
        end
        if (bcnt > 0) begin
            bcnt--; ebv0 = 0; ebv1 = 0;
        end else begin
            if (!ifb.csb0 && !ifb.web0 && ifb.addr0 < 200) begin
                m = expand(ifb.wmask0, 16);
                mb[ifb.addr0] = (mb[ifb.addr0] & ~m) | (ifb.din0 & m);
            end
            if (!ifb.csb1) begin eb1 = (ifb.addr1 < 200) ? mb[ifb.addr1] : 0; ebv1 = 1; end
            else ebv1 = 0;
            if (!ifb.csb0 && ifb.web0) begin eb0 = (ifb.addr0 < 200) ? mb[ifb.addr0] : 0; ebv0 = 1; end
            else ebv0 = 0;
        end
        #1;
        chk("a_dout0", ifa.dout0, ea0);        chk("a_v0", ifa.dout0_valid, eav0);
        chk("a_dout1", ifa.dout1, ea1);        chk("a_v1", ifa.dout1_valid, eav1);
        chk("a_busy", ifa.busy, 0);
        chk("b_dout0", ifb.dout0, eb0);        chk("b_v0", ifb.dout0_valid, ebv0);
        chk("b_dout1", ifb.dout1, eb1);        chk("b_v1", ifb.dout1_valid, ebv1);
        chk("b_busy", ifb.busy, bcnt > 0);
    endtask

    task automatic model_rst_b();
        eb0 = 0; eb1 = 0; ebv0 = 0; ebv1 = 0; bcnt = 200;
        for (int i = 0; i < 256; i++) mb[i] = 0;
    endtask

    // Pulse reset B between edges and check it takes effect without a clock.
    task automatic pulse_b();
        #2 rst_b = 1;
        #1 chk("b_async_dout0", ifb.dout0, 0); chk("b_async_v1", ifb.dout1_valid, 0);
        chk("b_async_busy", ifb.busy, 1);
        model_rst_b();
        #1 rst_b = 0;
    endtask

    task automatic sweep_len(input string tag);
        int cnt = 0;
        while (ifb.busy && cnt < 300) begin rnd(); step(); cnt++; end
        chk(tag, cnt, 200);
    endtask

    task automatic wr_a(input logic [7:0] a, input logic [31:0] d, input logic [3:0] m);
        ifa.csb0 = 0; ifa.web0 = 0; ifa.addr0 = a; ifa.din0 = d; ifa.wmask0 = m;
    endtask
    task automatic wr_b(input logic [7:0] a, input logic [63:0] d, input logic [3:0] m);
        ifb.csb0 = 0; ifb.web0 = 0; ifb.addr0 = a; ifb.din0 = d; ifb.wmask0 = m;
    endtask

    initial begin
        idle();
        for (int i = 0; i < 256; i++) ma[i] = 0;
        ea0 = 0; ea1 = 0; eav0 = 0; eav1 = 0;
        model_rst_b();
        rst_a = 1; rst_b = 1;
        #1;
        chk("rst_a_dout0", ifa.dout0, 0); chk("rst_a_v0", ifa.dout0_valid, 0);
        chk("rst_a_busy", ifa.busy, 0);   chk("rst_b_busy", ifb.busy, 1);
        chk("rst_b_dout1", ifb.dout1, 0); chk("rst_b_v1", ifb.dout1_valid, 0);
        #2 rst_a = 0; rst_b = 0;

        sweep_len("b_sweep_len");

        // Directed port-0 write/read and partial masks on A.
        idle(); wr_a(8'h10, 32'hDEADBEEF, 4'hF); step();
        ifa.web0 = 1; step(); chk("a_rd_deadbeef", ifa.dout0, 32'hDEADBEEF);
        wr_a(8'h10, 32'h11223344, 4'b0101); step();
        ifa.web0 = 1; step(); chk("a_partial", ifa.dout0, 32'hDE22BE44);
        wr_a(8'h10, 32'hFFFFFFFF, 4'h0); step();
        ifa.web0 = 1; step(); chk("a_mask0", ifa.dout0, 32'hDE22BE44);

        // Collision on both configurations.
        idle(); wr_a(8'd5, 32'hAAAAAAAA, 4'hF); wr_b(8'd5, 64'hAAAAAAAAAAAAAAAA, 4'hF); step();
        wr_a(8'd5, 32'h55555555, 4'hF); ifa.csb1 = 0; ifa.addr1 = 8'd5;
        wr_b(8'd5, 64'h5555555555555555, 4'hF); ifb.csb1 = 0; ifb.addr1 = 8'd5; step();
        chk("a_rdw_old", ifa.dout1, 32'hAAAAAAAA); chk("b_rdw_new", ifb.dout1, 64'h5555555555555555);
        ifa.csb0 = 1; ifb.csb0 = 1; step();
        chk("a_rdw_after", ifa.dout1, 32'h55555555); chk("b_rdw_after", ifb.dout1, 64'h5555555555555555);

        // Wide granules and out-of-range addresses on B.
        idle(); wr_b(8'd7, 64'h0, 4'hF); step();
        wr_b(8'd7, 64'hFFFFFFFFFFFFFFFF, 4'b1001); step();
        ifb.web0 = 1; step(); chk("b_mask1001", ifb.dout0, 64'hFFFF00000000FFFF);
        wr_b(8'd210, 64'h123456789ABCDEF0, 4'hF); step();
        ifb.web0 = 1; step(); chk("b_oor_data", ifb.dout0, 0); chk("b_oor_valid", ifb.dout0_valid, 1);

        // Async reset of A while a read result is on the output.
        idle(); ifa.csb0 = 0; ifa.web0 = 1; ifa.addr0 = 8'h10; step();
        idle();
        #2 rst_a = 1;
        #1 chk("a_async_dout0", ifa.dout0, 0); chk("a_async_v0", ifa.dout0_valid, 0);
        ea0 = 0; ea1 = 0; eav0 = 0; eav1 = 0;
        #1 rst_a = 0;

        for (int i = 0; i < 400; i++) begin rnd(); step(); end

        // Restart the sweep part-way through, then confirm every word is zero.
        pulse_b();
        for (int i = 0; i < 7; i++) begin rnd(); step(); end
        pulse_b();
        sweep_len("b_sweep_restart");
        idle();
        for (int i = 0; i < 200; i++) begin ifb.csb1 = 0; ifb.addr1 = 8'(i); step(); end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
